// File: rtl/au_serial_unit.sv
// Bit-serial arithmetic unit: streams two WIDTH-bit operands LSB-first through a
// single 1-bit AU slice, keeping the running carry in a flip-flop.
module au_serial_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s0,
   input  logic             s1,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic [1:0]       sel_reg, sel_next;
   logic             carry_reg, carry_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [WIDTH-1:0] res_reg, res_next;
   logic [WIDTH-1:0] d_reg, d_next;
   logic             cout_reg, cout_next;

   logic             y_bit;
   logic             sum_bit;
   logic             slice_carry;
   logic [WIDTH-1:0] res_shifted;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sel_reg   <= '0;
         carry_reg <= 1'b0;
         count_reg <= '0;
         res_reg   <= '0;
         d_reg     <= '0;
         cout_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         sel_reg   <= sel_next;
         carry_reg <= carry_next;
         count_reg <= count_next;
         res_reg   <= res_next;
         d_reg     <= d_next;
         cout_reg  <= cout_next;
      end
   end

   // The slice always looks at bit 0 of the operand shift registers.
   always_comb begin
      case (sel_reg)
         2'b00:   y_bit = b_reg[0];
         2'b01:   y_bit = ~b_reg[0];
         2'b10:   y_bit = 1'b0;
         default: y_bit = 1'b1;
      endcase
      sum_bit     = a_reg[0] ^ y_bit ^ carry_reg;
      slice_carry = (a_reg[0] & y_bit) | (a_reg[0] & carry_reg) | (y_bit & carry_reg);
      res_shifted = {sum_bit, res_reg[WIDTH-1:1]};
   end

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      sel_next   = sel_reg;
      carry_next = carry_reg;
      count_next = count_reg;
      res_next   = res_reg;
      d_next     = d_reg;
      cout_next  = cout_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               a_next     = a;
               b_next     = b;
               sel_next   = {s1, s0};
               carry_next = ci;
               count_next = '0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy       = 1'b1;
            a_next     = a_reg >> 1;
            b_next     = b_reg >> 1;
            res_next   = res_shifted;
            carry_next = slice_carry;
            count_next = count_reg + CW'(1);
            // MSB is processed on the same edge that publishes the word.
            if (count_reg == LAST) begin
               d_next     = res_shifted;
               cout_next  = slice_carry;
               count_next = '0;
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign d    = d_reg;
   assign cout = cout_reg;

endmodule
